// File: rtl/msweep_pkg.sv
// Shared types and constants for the minesweeper board engine.
package msweep_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLACE  = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_COUNT  = 3'd4,
      S_UPDATE = 3'd5,
      S_DONE   = 3'd6,
      S_OVER   = 3'd7
   } state_e;

   localparam int CNT_W = 4;

   // Neighbour visit order: NW, N, NE, W, E, SW, S, SE
   localparam int NB_DROW [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
   localparam int NB_DCOL [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

endpackage

// File: rtl/msweep_board_engine_lcg.sv
// 16-bit LCG step register with load/enable and a mod-CELLS candidate output.
// Only built when MSWEEP_LCG_EN is defined.
`ifdef MSWEEP_LCG_EN
module msweep_lcg
   import msweep_pkg::*;
#(
   parameter int CELLS = 25,
   localparam int CW   = $clog2(CELLS)
) (
   input  logic          in_clk,
   input  logic          in_restart_n,
   input  logic          in_load,
   input  logic          in_en,
   input  logic [15:0]   in_seed,
   input  logic [15:0]   in_mult,
   input  logic [15:0]   in_inc,
   output logic [CW-1:0] out_cand
);

   logic [15:0] r_x;

   always_ff @(posedge in_clk or negedge in_restart_n) begin
      if (!in_restart_n)  r_x <= '0;
      else if (in_load)   r_x <= in_seed;
      else if (in_en)     r_x <= r_x * in_mult + in_inc;
   end

   assign out_cand = CW'(r_x % 16'(CELLS));

endmodule
`endif

// File: rtl/msweep_board_engine.sv
// Minesweeper board engine: mine/cleared maps, reveal FSM with 8-step neighbour count,
// score and win/gameover tracking. MSWEEP_LCG_EN selects on-chip LCG mine placement.
module msweep_board_engine
   import msweep_pkg::*;
#(
   parameter int ROWS      = 5,
   parameter int COLS      = 5,
   parameter int SCORE_W   = 32,
   parameter int NUM_MINES = 3,
   localparam int CELLS    = ROWS * COLS,
   localparam int IDX_W    = $clog2(CELLS)
) (
   input  logic               in_clk,
   input  logic               in_restart_n,
   input  logic               in_place,
   input  logic [CELLS-1:0]   in_mines,
`ifdef MSWEEP_LCG_EN
   input  logic [15:0]        in_lcg_seed,
   input  logic [15:0]        in_lcg_mult,
   input  logic [15:0]        in_lcg_inc,
`endif
   input  logic               in_req_valid,
   output logic               out_req_ready,
   input  logic [IDX_W-1:0]   in_req_idx,
   output logic               out_rsp_valid,
   output logic [CNT_W-1:0]   out_rsp_count,
   output logic               out_rsp_err,
   output logic [2:0]         out_state,
   output logic [CELLS-1:0]   out_mines,
   output logic [CELLS-1:0]   out_cleared,
   output logic [SCORE_W-1:0] out_score,
   output logic               out_gameover,
   output logic               out_win
);

   localparam logic [CELLS-1:0] ONE = {{(CELLS-1){1'b0}}, 1'b1};

   state_e             r_state;
   logic [CELLS-1:0]   r_mines, r_cleared;
   logic [SCORE_W-1:0] r_score;
   logic               r_gameover, r_win;
   logic [IDX_W-1:0]   r_idx;
   logic [3:0]         r_row, r_col;
   logic [2:0]         r_nb;
   logic [CNT_W-1:0]   r_cnt, r_rsp_count;
   logic               r_rsp_valid, r_rsp_err, r_rsp_pend;

   logic               w_abort;
   logic [CELLS-1:0]   w_mine_sh, w_clr_sh, w_nb_sh, w_clr_nx;
   logic               w_idx_ok, w_idx_mine, w_already, w_nb_hit, w_win;
   int                 w_nr, w_nc, w_nb_cell;

   assign w_abort    = in_place && (r_state != S_PLACE);
   assign w_idx_ok   = int'(r_idx) < CELLS;
   assign w_mine_sh  = r_mines >> r_idx;
   assign w_clr_sh   = r_cleared >> r_idx;
   assign w_idx_mine = w_mine_sh[0];
   assign w_already  = w_clr_sh[0];
   assign w_clr_nx   = r_cleared | (ONE << r_idx);
   assign w_win      = ($countones(w_clr_nx) == (CELLS - $countones(r_mines)));

   // Off-board neighbours are masked out before the shifted map bit is used
   assign w_nr      = int'(r_row) + NB_DROW[r_nb];
   assign w_nc      = int'(r_col) + NB_DCOL[r_nb];
   assign w_nb_cell = w_nr * COLS + w_nc;
   assign w_nb_sh   = r_mines >> w_nb_cell;
   assign w_nb_hit  = (w_nr >= 0) && (w_nr < ROWS) && (w_nc >= 0) && (w_nc < COLS) && w_nb_sh[0];

`ifdef MSWEEP_LCG_EN
   localparam int PW = $clog2(NUM_MINES + 1);
   logic [PW-1:0]    r_placed;
   logic [IDX_W-1:0] w_cand;
   logic [CELLS-1:0] w_cand_sh;

   msweep_lcg #(.CELLS(CELLS)) u_lcg (
      .in_clk       (in_clk),
      .in_restart_n (in_restart_n),
      .in_load      (w_abort),
      .in_en        (r_state == S_PLACE),
      .in_seed      (in_lcg_seed),
      .in_mult      (in_lcg_mult),
      .in_inc       (in_lcg_inc),
      .out_cand     (w_cand)
   );

   assign w_cand_sh = r_mines >> w_cand;
`endif

   always_ff @(posedge in_clk or negedge in_restart_n) begin
      if (!in_restart_n) begin
         r_state     <= S_IDLE;
         r_mines     <= '0;
         r_cleared   <= '0;
         r_score     <= '0;
         r_gameover  <= 1'b0;
         r_win       <= 1'b0;
         r_idx       <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_nb        <= '0;
         r_cnt       <= '0;
         r_rsp_count <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_pend  <= 1'b0;
`ifdef MSWEEP_LCG_EN
         r_placed    <= '0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_abort) begin
            r_state    <= S_PLACE;
            r_cleared  <= '0;
            r_score    <= '0;
            r_gameover <= 1'b0;
            r_win      <= 1'b0;
            r_rsp_pend <= 1'b0;
`ifdef MSWEEP_LCG_EN
            r_mines    <= '0;
            r_placed   <= '0;
`endif
         end else begin
            case (r_state)
               S_PLACE: begin
`ifdef MSWEEP_LCG_EN
                  if (!w_cand_sh[0]) begin
                     r_mines  <= r_mines | (ONE << w_cand);
                     r_placed <= r_placed + PW'(1);
                     if (r_placed + PW'(1) == PW'(NUM_MINES)) r_state <= S_WAIT;
                  end
`else
                  r_mines <= in_mines;
                  r_state <= S_WAIT;
`endif
               end
               S_WAIT: begin
                  if (in_req_valid) begin
                     r_idx   <= in_req_idx;
                     r_state <= S_DECODE;
                  end
               end
               S_DECODE: begin
                  if (!w_idx_ok || w_idx_mine) begin
                     // Short path defers its pulse to the S_DONE exit edge (2-edge latency)
                     r_rsp_err   <= !w_idx_ok;
                     r_rsp_count <= '0;
                     r_rsp_pend  <= 1'b1;
                     if (w_idx_ok) r_gameover <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_row   <= 4'(int'(r_idx) / COLS);
                     r_col   <= 4'(int'(r_idx) % COLS);
                     r_cnt   <= '0;
                     r_nb    <= '0;
                     r_state <= S_COUNT;
                  end
               end
               S_COUNT: begin
                  r_cnt <= r_cnt + CNT_W'(w_nb_hit);
                  r_nb  <= r_nb + 3'd1;
                  if (r_nb == 3'd7) r_state <= S_UPDATE;
               end
               S_UPDATE: begin
                  if (!w_already) begin
                     r_cleared <= w_clr_nx;
                     if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + SCORE_W'(1);
                  end
                  r_win       <= w_win;
                  r_rsp_count <= r_cnt;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
               S_DONE: begin
                  r_rsp_valid <= r_rsp_pend;
                  r_rsp_pend  <= 1'b0;
                  r_state     <= (r_gameover || r_win) ? S_OVER : S_WAIT;
               end
               default: ;
            endcase
         end
      end
   end

   assign out_req_ready = (r_state == S_WAIT);
   assign out_rsp_valid = r_rsp_valid;
   assign out_rsp_count = r_rsp_count;
   assign out_rsp_err   = r_rsp_err;
   assign out_state     = r_state;
   assign out_mines     = r_mines;
   assign out_cleared   = r_cleared;
   assign out_score     = r_score;
   assign out_gameover  = r_gameover;
   assign out_win       = r_win;

endmodule

// File: doc/msweep_board_engine.md
Name: msweep_board_engine

Overview:
- Parametrised successor to the fixed 5x5 minesweeper datapath: one engine holds an ROWS x COLS mine map and cleared map, accepts reveal requests over a valid/ready handshake, and counts neighbouring mines (0..8) with edge clipping.
- It also maintains score, game-over and win status.
- Sits between the user-input front end and the display block; replaces the separate load/decode/ALU steps with one sequential FSM on a single clock.

Parameters:
- ROWS, 5, board rows (2..16)
- COLS, 5, board columns (2..16)
- SCORE_W, 32, score register width; the score saturates at all-ones
- NUM_MINES, 3, mines placed by the LCG generator (LCG build only; must be < ROWS*COLS)

Ports:
- in_clk  in  1  single clock; all state updates on the rising edge
- in_restart_n  in  1  asynchronous active-low reset
- in_place  in  1  start new game; sampled in any state except S_PLACE
- in_mines  in  CELLS  mine bitmap captured on in_place; bit i = cell i = row*COLS+col (non-LCG build)
- in_req_valid  in  1  reveal request valid
- out_req_ready  out  1  high only in S_WAIT
- in_req_idx  in  IDX_W  cell index; IDX_W = $clog2(CELLS)
- out_rsp_valid  out  1  one-cycle response pulse
- out_rsp_count  out  4  neighbour mine count for the response
- out_rsp_err  out  1  qualifies out_rsp_valid: index out of range
- out_state  out  3  FSM state encoding
- out_mines  out  CELLS  current mine map
- out_cleared  out  CELLS  current cleared map
- out_score  out  SCORE_W  number of newly cleared cells
- out_gameover  out  1  sticky; set on a mine hit
- out_win  out  1  sticky; set when every non-mine cell is cleared

Behaviour:
- Reset (async, in_restart_n=0): state=S_IDLE; all outputs, maps, score and flags = 0.
- States: S_IDLE=0, S_PLACE=1, S_WAIT=2, S_DECODE=3, S_COUNT=4, S_UPDATE=5, S_DONE=6, S_OVER=7.
- in_place=1 in any state except S_PLACE:
  - aborts current activity and goes to S_PLACE;
  - clears the cleared map, score, gameover and win;
  - no response is issued for an aborted request.
- S_PLACE:
  - non-LCG build: latch in_mines in 1 cycle, then go to S_WAIT.
  - LCG build: see Optional Feature.
- S_WAIT:
  - out_req_ready=1.
  - On the handshake edge: latch in_req_idx and go to S_DECODE.
- S_DECODE:
  - idx >= CELLS: set err and go to S_DONE with count=0.
  - Mine at idx: set gameover and go to S_DONE with count=0.
  - Otherwise: compute row/col, clear the counter, go to S_COUNT.
- S_COUNT:
  - Exactly 8 cycles, one neighbour per cycle, in order NW,N,NE,W,E,SW,S,SE.
  - Off-board neighbours contribute 0.
  - Counter width is 4 bits and never exceeds 8.
- S_UPDATE:
  - If the cell was not already cleared: set its cleared bit and score+1 (saturating).
  - A repeat reveal leaves score unchanged but still responds with its count.
  - Win is evaluated here: popcount(cleared) == CELLS - popcount(mines).
- S_DONE:
  - out_rsp_valid=1 for one cycle, with out_rsp_count and out_rsp_err.
  - Next state is S_OVER if gameover or win, else S_WAIT.
- Response latency, counted in rising edges from the accept edge:
  - normal reveal: 10 (rsp_valid visible after edge 10);
  - error or mine hit: 2.
- S_OVER: ignores requests (ready=0); leaves only on in_place.
- in_req_valid outside S_WAIT: ignored, no effect.
- Simultaneous in_place and a request handshake: in_place wins.

Optional Feature:
- Macro: MSWEEP_LCG_EN.
- Defined:
  - adds inputs in_lcg_seed[15:0], in_lcg_mult[15:0], in_lcg_inc[15:0]; in_mines is unused.
  - S_PLACE loads x=in_lcg_seed and clears the mine map.
  - Each cycle: x <= x*in_lcg_mult + in_lcg_inc (mod 2^16); candidate = x % CELLS.
  - If the candidate is not already a mine, set it and count it.
  - Exit to S_WAIT when NUM_MINES mines are placed.
  - Full-period parameters (odd increment, mult%4==1) guarantee termination.
- Undefined: the LCG ports are absent; placement comes from in_mines in 1 cycle.

Decomposition:
- Package msweep_pkg holds:
  - state enum and its encodings;
  - neighbour order table (dRow/dCol, -1..+1) as constants;
  - count width constant (4).
- One sub-module: msweep_lcg, the 16-bit LCG step register with load, enable and mod-CELLS output; instantiated only under MSWEEP_LCG_EN.

Test Plan:
- Neighbour count: 5x5, in_mines=25'h41 (cells 0,6), reveal idx 1 -> rsp after 10 cycles, count=2, score=1, cleared bit 1 set.
- Corner clipping and repeat: reveal idx 24 -> count=0, score=2; reveal idx 1 again -> count=2, score stays 2.
- Error path: idx 25 -> rsp after 2 cycles, err=1, count=0, maps and score unchanged, back to S_WAIT.
- Mine hit: reveal idx 0 -> rsp after 2 cycles, gameover=1, state=S_OVER, ready=0; in_place -> gameover=0, score=0.
- Win: in_mines=25'h1, reveal idx 1..24 -> win=1 after 24th response, score=24, state=S_OVER.
- Async reset: drop in_restart_n mid-S_COUNT -> all outputs 0 immediately, state=S_IDLE; LCG build: seed 1, mult 5, inc 3, NUM_MINES=3 -> exactly 3 mine bits set, deterministic across runs.
